if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Fetch-side writer of the 64-bit IF/ID pipeline bundle that the ID-stage decoder consumes.
- Owns the PC and issues one-outstanding word requests to instruction memory.
- Packs each returned instruction with its PC+4 into ifid_reg.
- Honours ID stall and flush, and branch/jump redirects from ID/EX.
- Sits between the instruction memory port and the ID-stage decode and control logic.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0) written into ifid_reg on flush or reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  one-cycle fetch request strobe; memory always accepts it.
- imem_addr  output  32  word address of the request; equals pc, with bits [1:0]=00.
- imem_rvalid  input  1  read data valid; arrives 1 or more cycles after imem_req.
- imem_rdata  input  32  instruction word.
- id_stall  input  1  hazard unit: ID holds its current instruction.
- id_flush  input  1  squash the instruction currently in IF/ID.
- redirect_valid  input  1  control-flow change; also squashes IF/ID.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 00.
- ifid_reg  output  64  [63:32] = PC+4 of the instruction, [31:0] = instruction.
- ifid_valid  output  1  ifid_reg holds a real (non-bubble) instruction.
- fetch_pc  output  32  current pc register (debug and trace).

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst takes priority over everything.
  - Reset values: pc=RESET_PC, state=ISSUE, ifid_reg={32'h0,NOP_WORD}, ifid_valid=0, buffer empty.
  - imem_req is 0 during the reset cycle.
  - Reset asserted mid-request: any later imem_rvalid for that request is ignored, because state is ISSUE, not WAIT.
- Accept condition: accept = !ifid_valid | !id_stall | id_flush.
- States (Moore outputs: imem_req=(state==ISSUE), imem_addr=pc):
  - ISSUE: drive request, then go to WAIT.
  - WAIT: on imem_rvalid:
    - If accept: ifid_reg<={pc+32'd4, imem_rdata}, ifid_valid<=1, pc<=pc+4, go to ISSUE.
    - Else: buf<=imem_rdata, go to HOLD.
    - No rvalid: remain in WAIT.
  - HOLD: when accept: ifid_reg<={pc+4, buf}, ifid_valid<=1, pc<=pc+4, buf emptied, go to ISSUE. No new request is issued while in HOLD.
  - DROP: the request in flight belongs to a squashed path. On imem_rvalid, discard the data and go to ISSUE.
- id_flush without redirect, when no instruction is loaded that cycle: ifid_reg<={32'h0,NOP_WORD}, ifid_valid<=0.
- id_flush together with a load: the load wins. The old contents are squashed and the new instruction enters.
- redirect_valid (priority over flush, stall and load):
  - pc<=redirect_pc&~32'h3.
  - ifid_reg<=bubble, ifid_valid<=0, buf emptied.
  - Next state:
    - from ISSUE: DROP (a request was issued this cycle).
    - from WAIT without rvalid: DROP.
    - from WAIT with rvalid: ISSUE (data discarded).
    - from HOLD: ISSUE.
    - from DROP without rvalid: DROP.
    - from DROP with rvalid: ISSUE.
- Stall with ifid_valid=1: ifid_reg and ifid_valid hold bit-exact.
- Throughput: at most one instruction every 2 cycles (ISSUE then WAIT). Never more than one request outstanding.
- pc arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
- Unused encodings: an illegal state recovers to ISSUE on the next clock.

Decomposition:
- Shared header/package:
  - 2-bit state encodings (ISSUE, WAIT, HOLD, DROP).
  - NOP_WORD.
  - IF/ID field positions: IFID_PC4_HI=63, IFID_PC4_LO=32, IFID_INSTR_HI=31, IFID_INSTR_LO=0. The ID-stage decoder uses the same constants.
- Sub-module: if_fetch_buf, a one-entry holding register.
  - Signals: load, clear, full, data.
  - Instantiated for HOLD storage.
- The FSM, pc register and output register stay in if_fetch_stage.

Test Plan:
- Reset, then straight-line fetch with 1-cycle memory latency returning 32'h2008_0005, 32'h2009_0007:
  - imem_addr = 32'h3000, 32'h3004.
  - ifid_reg = {32'h3004,32'h20080005}, then {32'h3008,32'h20090007}.
  - ifid_valid rises 2 cycles after reset release.
- id_stall held 5 cycles while a response (32'h0109_5020) arrives:
  - ifid_reg is unchanged and the response enters HOLD.
  - No imem_req is issued during the stall.
  - On stall release, ifid_reg={pc+4,32'h01095020} on the next edge.
- redirect_valid with redirect_pc=32'h0000_4002 while in WAIT, response 32'hDEAD_BEEF arriving 3 cycles later:
  - The response is dropped.
  - Next imem_addr=32'h4000.
  - ifid_valid=0 until the new fetch returns.
- id_flush with no simultaneous response: ifid_reg={32'h0,32'h0}, ifid_valid=0. Same-cycle flush plus rvalid: the new instruction is loaded with ifid_valid=1.
- PC wrap: redirect to 32'hFFFF_FFFC, then fetch. ifid_reg[63:32]=32'h0 and the next imem_addr=32'h0.
- rst asserted during WAIT with rvalid in the same cycle and the next cycle: the data is ignored and imem_addr returns to RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the IF stage and the ID-stage decoder:
// fetch FSM encodings, the bubble word and the IF/ID bundle layout.
package if_fetch_stage_pkg;

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int IFID_PC4_HI   = 63;
    localparam int IFID_PC4_LO   = 32;
    localparam int IFID_INSTR_HI = 31;
    localparam int IFID_INSTR_LO = 0;

    function automatic logic [63:0] ifid_pack(input logic [31:0] pc4, input logic [31:0] instr);
        logic [63:0] r;
        r = '0;
        r[IFID_PC4_HI:IFID_PC4_LO]     = pc4;
        r[IFID_INSTR_HI:IFID_INSTR_LO] = instr;
        return r;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry holding register for an instruction that returned while ID was stalled.
module if_fetch_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= din;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and writes the IF/ID bundle consumed by the decoder.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ISSUE | drive imem_req for pc this cycle
// ST_WAIT  | request outstanding, waiting for imem_rvalid
// ST_HOLD  | response parked in if_fetch_buf until ID accepts it
// ST_DROP  | outstanding request belongs to a squashed path; discard it
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = if_fetch_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        id_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [63:0] ifid_reg,
    output logic        ifid_valid,
    output logic [31:0] fetch_pc
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        accept;
    logic        load_rdata;
    logic        load_held;
    logic        buf_load;
    logic        buf_clear;
    logic        buf_full;
    logic [31:0] buf_data;

    assign accept     = !ifid_valid || !id_stall || id_flush;
    assign pc_plus4   = pc + 32'd4;
    assign load_rdata = (state == ST_WAIT) && imem_rvalid && accept;
    assign load_held  = (state == ST_HOLD) && buf_full && accept;
    assign buf_load   = (state == ST_WAIT) && imem_rvalid && !accept && !redirect_valid;
    assign buf_clear  = redirect_valid || load_held;

    // Gated by rst so no request escapes while the stage is being reset.
    assign imem_req  = (state == ST_ISSUE) && !rst;
    assign imem_addr = {pc[31:2], 2'b00};
    assign fetch_pc  = pc;

    always_comb begin
        state_nxt = ST_ISSUE;
        case (state)
            ST_ISSUE: state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid)
                    state_nxt = (redirect_valid || accept) ? ST_ISSUE : ST_HOLD;
                else
                    state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
            end
            ST_HOLD:  state_nxt = (redirect_valid || load_held) ? ST_ISSUE : ST_HOLD;
            ST_DROP:  state_nxt = imem_rvalid ? ST_ISSUE : ST_DROP;
            default:  state_nxt = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ISSUE;
            pc         <= RESET_PC;
            ifid_reg   <= ifid_pack(32'h0, NOP_WORD);
            ifid_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc         <= redirect_pc & ~32'h3;
                ifid_reg   <= ifid_pack(32'h0, NOP_WORD);
                ifid_valid <= 1'b0;
            end else if (load_rdata || load_held) begin
                pc         <= pc_plus4;
                ifid_reg   <= ifid_pack(pc_plus4, load_held ? buf_data : imem_rdata);
                ifid_valid <= 1'b1;
            end else if (id_flush) begin
                ifid_reg   <= ifid_pack(32'h0, NOP_WORD);
                ifid_valid <= 1'b0;
            end
        end
    end

    if_fetch_buf #(.W(32)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (imem_rdata),
        .full  (buf_full),
        .data  (buf_data)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bench plays instruction memory cycle by cycle.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        id_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [63:0] ifid_reg;
    logic        ifid_valid;
    logic [31:0] fetch_pc;

    int n_pass;
    int n_total;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .id_flush       (id_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_reg       (ifid_reg),
        .ifid_valid     (ifid_valid),
        .fetch_pc       (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        id_stall = 1'b0;
        id_flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        tick();
        tick();
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_ifid", ifid_reg, 64'h0);
        check("rst_valid", {63'h0, ifid_valid}, 64'h0);
        check("rst_pc", {32'h0, fetch_pc}, 64'h3000);

        // straight-line fetch, 1-cycle latency
        rst = 1'b0;
        #1;
        check("sl_req0", {63'h0, imem_req}, 64'h1);
        check("sl_addr0", {32'h0, imem_addr}, 64'h3000);
        tick();
        check("sl_wait_req", {63'h0, imem_req}, 64'h0);
        check("sl_valid_early", {63'h0, ifid_valid}, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_rvalid = 1'b0;
        check("sl_ifid0", ifid_reg, {32'h3004, 32'h2008_0005});
        check("sl_valid0", {63'h0, ifid_valid}, 64'h1);
        check("sl_addr1", {32'h0, imem_addr}, 64'h3004);
        check("sl_req1", {63'h0, imem_req}, 64'h1);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2009_0007;
        tick();
        imem_rvalid = 1'b0;
        check("sl_ifid1", ifid_reg, {32'h3008, 32'h2009_0007});

        // stall for 5 cycles while a response arrives
        id_stall = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0109_5020;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st_hold_ifid", ifid_reg, {32'h3008, 32'h2009_0007});
            check("st_hold_valid", {63'h0, ifid_valid}, 64'h1);
            check("st_no_req", {63'h0, imem_req}, 64'h0);
            if (i < 3) tick();
        end
        id_stall = 1'b0;
        tick();
        check("st_release_ifid", ifid_reg, {32'h300C, 32'h0109_5020});
        check("st_release_addr", {32'h0, imem_addr}, 64'h300C);
        check("st_release_req", {63'h0, imem_req}, 64'h1);

        // redirect while in WAIT; stale response arrives 3 cycles later
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4002;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid", {63'h0, ifid_valid}, 64'h0);
        check("rd_ifid", ifid_reg, 64'h0);
        check("rd_pc", {32'h0, fetch_pc}, 64'h4000);
        check("rd_drop_req", {63'h0, imem_req}, 64'h0);
        tick();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("rd_dropped_valid", {63'h0, ifid_valid}, 64'h0);
        check("rd_req", {63'h0, imem_req}, 64'h1);
        check("rd_addr", {32'h0, imem_addr}, 64'h4000);
        tick();
        check("rd_wait_valid", {63'h0, ifid_valid}, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h8C08_0000;
        tick();
        imem_rvalid = 1'b0;
        check("rd_new_ifid", ifid_reg, {32'h4004, 32'h8C08_0000});
        check("rd_new_valid", {63'h0, ifid_valid}, 64'h1);

        // flush with no response, then flush together with a load under stall
        id_flush = 1'b1;
        tick();
        id_flush = 1'b0;
        check("fl_ifid", ifid_reg, 64'h0);
        check("fl_valid", {63'h0, ifid_valid}, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0085_1020;
        tick();
        imem_rvalid = 1'b0;
        check("fl_reload", ifid_reg, {32'h4008, 32'h0085_1020});
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0128_5020;
        id_flush = 1'b1; id_stall = 1'b1;
        tick();
        imem_rvalid = 1'b0; id_flush = 1'b0; id_stall = 1'b0;
        check("fl_load_ifid", ifid_reg, {32'h400C, 32'h0128_5020});
        check("fl_load_valid", {63'h0, ifid_valid}, 64'h1);

        // PC wrap: redirect from ISSUE goes to DROP
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wr_pc", {32'h0, fetch_pc}, 64'hFFFF_FFFC);
        check("wr_drop_req", {63'h0, imem_req}, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        check("wr_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
        check("wr_valid_after_drop", {63'h0, ifid_valid}, 64'h0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2402_0001;
        tick();
        imem_rvalid = 1'b0;
        check("wr_ifid", ifid_reg, {32'h0, 32'h2402_0001});
        check("wr_next_addr", {32'h0, imem_addr}, 64'h0);

        // reset during WAIT with rvalid this cycle and next
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; rst = 1'b1;
        tick();
        check("rs_req", {63'h0, imem_req}, 64'h0);
        check("rs_addr", {32'h0, imem_addr}, 64'h3000);
        check("rs_ifid", ifid_reg, 64'h0);
        check("rs_valid", {63'h0, ifid_valid}, 64'h0);
        imem_rdata = 32'h2222_2222; rst = 1'b0;
        #1;
        check("rs_req_after", {63'h0, imem_req}, 64'h1);
        tick();
        imem_rvalid = 1'b0;
        check("rs_ignored_valid", {63'h0, ifid_valid}, 64'h0);
        check("rs_ignored_ifid", ifid_reg, 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h3C01_0000;
        tick();
        imem_rvalid = 1'b0;
        check("rs_fetch_ifid", ifid_reg, {32'h3004, 32'h3C01_0000});
        check("rs_fetch_valid", {63'h0, ifid_valid}, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
